// File: rtl/syn_lb_csr_bank.sv
// syn_lb_csr_bank
// Local-bus control/status register bank.
//
// The bank provides these registers, in address order from BASE_ADDR:
//   - NUM_CTRL read/write control registers.
//   - STATUS: sticky event flags. Reading it clears them, and a write
//     clears the bits that are set in the write data.
//   - IRQ_MASK: interrupt mask.
//   - CNT[i]: one saturating, clear-on-read pulse counter per event.
// The interrupt is registered. Any address outside the bank reads
// 32'hdeadbabe. Writes to addresses outside the bank are ignored but
// still acknowledged.
//
// Ports
//   clk_ir        clock
//   rst_sync_l    asynchronous active-low reset
//   lb_wr_en      write strobe, one cycle per access
//   lb_rd_en      read strobe, one cycle per access
//   lb_addr       access address
//   lb_wr_data    write data
//   lb_wr_valid   write acknowledge, one cycle after lb_wr_en
//   lb_rd_valid   read data valid, one cycle after lb_rd_en
//   lb_rd_data    registered read data, held until the next read
//   evnt_i        event pulses; each high cycle counts as one event
//   ctrl_o        control registers; register k is at [k*DATA_W +: DATA_W]
//   irq_o         level interrupt, |(STATUS & IRQ_MASK), registered

module syn_lb_csr_bank #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h10,
    parameter int                NUM_CTRL  = 4,
    parameter int                NUM_EVNT  = 8,
    parameter int                CNTR_W    = 16
) (
    input  logic                       clk_ir,
    input  logic                       rst_sync_l,
    input  logic                       lb_wr_en,
    input  logic                       lb_rd_en,
    input  logic [ADDR_W-1:0]          lb_addr,
    input  logic [DATA_W-1:0]          lb_wr_data,
    output logic                       lb_wr_valid,
    output logic                       lb_rd_valid,
    output logic [DATA_W-1:0]          lb_rd_data,
    input  logic [NUM_EVNT-1:0]        evnt_i,
    output logic [NUM_CTRL*DATA_W-1:0] ctrl_o,
    output logic                       irq_o
);

    localparam int AW1      = ADDR_W + 1;
    localparam int STAT_OFS = NUM_CTRL;
    localparam int MASK_OFS = NUM_CTRL + 1;
    localparam int CNT_OFS  = NUM_CTRL + 2;
    localparam logic [DATA_W-1:0] UNMAPPED_VAL = DATA_W'(32'hdeadbabe);

    logic [DATA_W-1:0]   ctrl_q [NUM_CTRL];
    logic [NUM_EVNT-1:0] stat_q;
    logic [NUM_EVNT-1:0] mask_q;
    logic [CNTR_W-1:0]   cnt_q  [NUM_EVNT];

    logic [AW1-1:0]      addr_rel;
    logic [NUM_CTRL-1:0] sel_ctrl;
    logic                sel_stat;
    logic                sel_mask;
    logic [NUM_EVNT-1:0] sel_cnt;
    logic [DATA_W-1:0]   rd_mux;
    logic [NUM_EVNT-1:0] stat_nxt;
    logic [NUM_EVNT-1:0] w1c;
    logic                clr_rd;
    logic [CNTR_W-1:0]   cnt_nxt [NUM_EVNT];

    // The offset is computed one bit wider than the address. An address
    // below BASE_ADDR borrows into the top bit, which puts the offset
    // above every register offset, so it matches no register.
    assign addr_rel = {1'b0, lb_addr} - {1'b0, BASE_ADDR};

    always_comb begin
        sel_ctrl = '0;
        sel_cnt  = '0;
        for (int k = 0; k < NUM_CTRL; k++) begin
            sel_ctrl[k] = (addr_rel == AW1'(k));
        end
        sel_stat = (addr_rel == AW1'(STAT_OFS));
        sel_mask = (addr_rel == AW1'(MASK_OFS));
        for (int i = 0; i < NUM_EVNT; i++) begin
            sel_cnt[i] = (addr_rel == AW1'(CNT_OFS + i));
        end
    end

    always_comb begin
        rd_mux = UNMAPPED_VAL;
        for (int k = 0; k < NUM_CTRL; k++) begin
            if (sel_ctrl[k]) rd_mux = ctrl_q[k];
        end
        if (sel_stat) rd_mux = DATA_W'(stat_q);
        if (sel_mask) rd_mux = DATA_W'(mask_q);
        for (int i = 0; i < NUM_EVNT; i++) begin
            if (sel_cnt[i]) rd_mux = DATA_W'(cnt_q[i]);
        end
    end

    // An event that arrives in the same cycle as a clear keeps its flag set.
    always_comb begin
        clr_rd   = lb_rd_en & sel_stat;
        w1c      = (lb_wr_en & sel_stat) ? lb_wr_data[NUM_EVNT-1:0] : '0;
        stat_nxt = evnt_i | (stat_q & ~{NUM_EVNT{clr_rd}} & ~w1c);
    end

    // When a counter is read, the read returns the value before the clear.
    // An event in the same cycle as the read starts the new count at 1.
    always_comb begin
        for (int i = 0; i < NUM_EVNT; i++) begin
            cnt_nxt[i] = cnt_q[i];
            if (lb_rd_en && sel_cnt[i]) begin
                cnt_nxt[i] = CNTR_W'(evnt_i[i]);
            end else if (!(&cnt_q[i])) begin
                cnt_nxt[i] = cnt_q[i] + CNTR_W'(evnt_i[i]);
            end
        end
    end

    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            for (int k = 0; k < NUM_CTRL; k++) ctrl_q[k] <= '0;
            for (int i = 0; i < NUM_EVNT; i++) cnt_q[i] <= '0;
            stat_q      <= '0;
            mask_q      <= '0;
            lb_wr_valid <= 1'b0;
            lb_rd_valid <= 1'b0;
            lb_rd_data  <= '0;
            irq_o       <= 1'b0;
        end else begin
            lb_wr_valid <= lb_wr_en;
            lb_rd_valid <= lb_rd_en;
            if (lb_rd_en) lb_rd_data <= rd_mux;
            for (int k = 0; k < NUM_CTRL; k++) begin
                if (lb_wr_en && sel_ctrl[k]) ctrl_q[k] <= lb_wr_data;
            end
            if (lb_wr_en && sel_mask) mask_q <= lb_wr_data[NUM_EVNT-1:0];
            stat_q <= stat_nxt;
            for (int i = 0; i < NUM_EVNT; i++) cnt_q[i] <= cnt_nxt[i];
            irq_o <= |(stat_q & mask_q);
        end
    end

    for (genvar k = 0; k < NUM_CTRL; k++) begin : g_ctrl_o
        assign ctrl_o[k*DATA_W +: DATA_W] = ctrl_q[k];
    end

endmodule
